// File: rtl/tbuf_bus_arbiter_if.sv
// Bus-side signal bundle of the tristate bus arbiter.
// master: the arbiter (samples req, drives the enables and status).
// slave : the bus clients / pad macro (drive req, observe the enables).
// Optional macro TBUF_ARB_PARK_EN adds park_en for the bus keeper buffer.
interface tbuf_bus_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] en;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_valid;
    logic             turn;
`ifdef TBUF_ARB_PARK_EN
    logic             park_en;

    modport master (input req, output en, gnt_id, gnt_valid, turn, park_en);
    modport slave  (output req, input en, gnt_id, gnt_valid, turn, park_en);
`else
    modport master (input req, output en, gnt_id, gnt_valid, turn);
    modport slave  (output req, input en, gnt_id, gnt_valid, turn);
`endif
endinterface

// File: rtl/tbuf_bus_arbiter.sv
// Round-robin arbiter / sequencer for a shared bus of inverting tristate
// driver groups. Produces registered one-hot EN pins with break-before-make:
// every change of owner passes through TURN_CYC all-low turnaround cycles.
// Optional macro TBUF_ARB_PARK_EN: adds park_en for a bus keeper that is
// active only in IDLE; leaving IDLE then goes through TURN before DRIVE.
module tbuf_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic               CLK,
    input  logic               R,
    tbuf_bus_arbiter_if.master bus
);
    localparam int ID_W   = $clog2(N_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int TURN_W = $clog2(TURN_CYC + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

    state_t            state, state_nx;
    logic [N_REQ-1:0]  en_q, en_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic              turn_q, turn_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [TURN_W-1:0] tcnt_q, tcnt_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              park_q, park_d;

    logic              any_req;
    logic [ID_W-1:0]   sel;
    logic              rel;
    logic              turn_last;
    logic              grant;
    int                idx;

    assign any_req   = |bus.req;
    assign turn_last = (tcnt_q == TURN_W'(TURN_CYC));
    // In DRIVE en_q is the owner's one-hot, so it doubles as the owner mask.
    assign rel = !(|(bus.req & en_q)) ||
                 ((hold_q == HOLD_W'(MAX_HOLD)) && (|(bus.req & ~en_q)));

    // Round-robin pick: first set request above the last owner, wrapping.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sel = '0;
        idx = 0;
        // Scan farthest-first so the nearest set bit above the pointer wins.
        for (int k = N_REQ; k >= 1; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (bus.req[idx]) sel = ID_W'(idx);
        end
    end

    // State and output registers; everything clears asynchronously on R low.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state       <= IDLE;
            en_q        <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            turn_q      <= 1'b0;
            hold_q      <= '0;
            tcnt_q      <= '0;
            ptr_q       <= ID_W'(N_REQ - 1);
            park_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            en_q        <= en_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            turn_q      <= turn_d;
            hold_q      <= hold_d;
            tcnt_q      <= tcnt_d;
            ptr_q       <= ptr_d;
            park_q      <= park_d;
        end
    end

    // Next-state decision: IDLE -> DRIVE (or TURN with a keeper), DRIVE -> TURN, TURN -> DRIVE/IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
`ifdef TBUF_ARB_PARK_EN
                if (any_req) state_nx = TURN;
`else
                if (any_req) state_nx = DRIVE;
`endif
            end
            DRIVE:   if (rel) state_nx = TURN;
            TURN:    if (turn_last) state_nx = any_req ? DRIVE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs and counters for each transition.
    always_comb begin
        en_d        = en_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        turn_d      = turn_q;
        hold_d      = hold_q;
        tcnt_d      = tcnt_q;
        ptr_d       = ptr_q;
        grant       = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
`ifdef TBUF_ARB_PARK_EN
                    // Keeper drops now; drivers wait out a full turnaround.
                    turn_d = 1'b1;
                    tcnt_d = TURN_W'(1);
`else
                    grant = 1'b1;
`endif
                end
            end
            DRIVE: begin
                if (rel) begin
                    en_d        = '0;
                    gnt_valid_d = 1'b0;
                    turn_d      = 1'b1;
                    tcnt_d      = TURN_W'(1);
                    ptr_d       = gnt_id_q;
                end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            TURN: begin
                if (turn_last) begin
                    turn_d = 1'b0;
                    grant  = any_req;
                end else begin
                    tcnt_d = tcnt_q + TURN_W'(1);
                end
            end
            default: ;
        endcase
        if (grant) begin
            en_d        = N_REQ'(1) << sel;
            gnt_id_d    = sel;
            gnt_valid_d = 1'b1;
            hold_d      = HOLD_W'(1);
            turn_d      = 1'b0;
        end
        park_d = (state_nx == IDLE);
    end

    assign bus.en        = en_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.turn      = turn_q;
`ifdef TBUF_ARB_PARK_EN
    assign bus.park_en   = park_q;
`endif
endmodule
